// File: rtl/scanline_scheduler.sv
// Scanline scheduler: pixel-clock divider, frame pulse/counter and per-line fetch FSM.
// Optional underrun reporting is enabled by defining SCHED_UNDERRUN_EN.
module scanline_scheduler #(
  parameter int PIXEL_DIV   = 1,
  parameter int V_RES       = 480,
  parameter int FETCH_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               h_next,
  input  logic               v_next,
  input  logic               h_blank,
  input  logic signed [10:0] v_counter,
  input  logic               fast_scan,
  input  logic               fetch_ack,
  input  logic               underrun_clr,
  output logic               h_enable,
  output logic               v_enable,
  output logic               inc_1_or_4,
  output logic               fetch_req,
  output logic [3:0]         fetch_idx,
  output logic [9:0]         fetch_line,
  output logic               frame_start,
  output logic [7:0]         frame_count,
  output logic               underrun
);

  localparam int DW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic signed [10:0] LAST_FETCH_V = 11'(V_RES - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t               r_state;
  logic [DW-1:0]        r_div;
  logic                 r_fs;
  logic [7:0]           r_fc;
  logic                 r_inc;
  logic                 r_req;
  logic [3:0]           r_idx;
  logic [9:0]           r_line;
  logic signed [10:0]   w_vnext;
  logic                 w_start;
  logic                 w_last;
  logic                 w_abort;

  // Divider sits at 0 out of reset so the first edge already carries h_enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_div <= '0;
    else if (r_div == DW'(PIXEL_DIV - 1))  r_div <= '0;
    else                                   r_div <= r_div + 1'b1;
  end

  assign h_enable = reset_n & (r_div == '0);
  assign v_enable = h_next;

  // Scan mode is latched only while frame_start is high, so it changes on frame boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fs  <= 1'b0;
      r_fc  <= '0;
      r_inc <= 1'b0;
    end else begin
      r_fs <= v_next & v_enable;
      if (r_fs) begin
        r_fc  <= r_fc + 8'd1;
        r_inc <= fast_scan;
      end
    end
  end

  assign w_vnext = v_counter + 11'sd1;
  assign w_start = h_next && (v_counter >= -11'sd1) && (v_counter <= LAST_FETCH_V);
  assign w_last  = (r_idx == 4'(FETCH_WORDS - 1));
  // Visible region started before the final word landed; a coincident final ack still completes.
  assign w_abort = (r_state == S_REQ) && !h_blank && !(fetch_ack && w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_idx   <= '0;
      r_line  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_idx   <= '0;
          r_line  <= w_vnext[9:0];
        end
        S_REQ: begin
          if (fetch_ack && w_last) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
          end else if (w_abort) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (fetch_ack) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_DONE: if (!h_blank) r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCHED_UNDERRUN_EN
  logic r_underrun;
  logic w_unused;
  assign w_unused = w_vnext[10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_underrun <= 1'b0;
    else if (w_abort)      r_underrun <= 1'b1;
    else if (underrun_clr) r_underrun <= 1'b0;
  end

  assign underrun = r_underrun;
`else
  logic w_unused;
  assign w_unused = ^{underrun_clr, w_vnext[10]};
  assign underrun = 1'b0;
`endif

  assign inc_1_or_4  = r_inc;
  assign fetch_req   = r_req;
  assign fetch_idx   = r_idx;
  assign fetch_line  = r_line;
  assign frame_start = r_fs;
  assign frame_count = r_fc;

endmodule
